// File: rtl/pipe_reg_multi.sv
`default_nettype none
// ============================================================================
// Module : pipe_reg_multi
// Brief  : Multi-lane EX->MEM->WB pipeline registers with kill, stall, flush
//          and saturating stall/kill performance counters.
// Rev    : 1.0
// ============================================================================
module pipe_reg_multi #(
    parameter int LANES = 2,
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int MTW   = 3,
    parameter int SW    = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall_dcache,
    input  logic                 flush_all,
    input  logic [LANES-1:0]     ex_valid,
    input  logic [LANES-1:0]     ex_br,
    input  logic [LANES-1:0]     ex_rf_we,
    input  logic [LANES*DW-1:0]  ex_alu_result,
    input  logic [LANES*AW-1:0]  ex_rf_waddr,
    input  logic [LANES*MTW-1:0] ex_mem_type,
    input  logic [LANES*SW-1:0]  ex_wb_sel,
    output logic [LANES-1:0]     mem_valid,
    output logic [LANES-1:0]     mem_rf_we,
    output logic [LANES*DW-1:0]  mem_alu_result,
    output logic [LANES*AW-1:0]  mem_rf_waddr,
    output logic [LANES*MTW-1:0] mem_mem_type,
    output logic [LANES*SW-1:0]  mem_wb_sel,
    input  logic [LANES*DW-1:0]  mem_rf_wdata,
    output logic [LANES-1:0]     wb_valid,
    output logic [LANES-1:0]     wb_rf_we,
    output logic [LANES*DW-1:0]  wb_alu_result,
    output logic [LANES*DW-1:0]  wb_rf_wdata,
    output logic [LANES*AW-1:0]  wb_rf_waddr,
    output logic [31:0]          stall_cnt,
    output logic [31:0]          kill_cnt
);

    logic [LANES-1:0] w_br_live;
    logic [LANES-1:0] w_kill;
    logic             w_capture;
    logic [2:0]       w_kill_pop;
    logic [32:0]      w_kill_sum;

    logic [LANES-1:0]     mem_valid_q, mem_valid_d;
    logic [LANES-1:0]     mem_rf_we_q, mem_rf_we_d;
    logic [LANES*DW-1:0]  mem_alu_q, mem_alu_d;
    logic [LANES*AW-1:0]  mem_waddr_q, mem_waddr_d;
    logic [LANES*MTW-1:0] mem_mtype_q, mem_mtype_d;
    logic [LANES*SW-1:0]  mem_wbsel_q, mem_wbsel_d;

    logic [LANES-1:0]     wb_valid_q, wb_valid_d;
    logic [LANES-1:0]     wb_rf_we_q, wb_rf_we_d;
    logic [LANES*DW-1:0]  wb_alu_q, wb_alu_d;
    logic [LANES*DW-1:0]  wb_wdata_q, wb_wdata_d;
    logic [LANES*AW-1:0]  wb_waddr_q, wb_waddr_d;

    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] kill_cnt_q, kill_cnt_d;

    assign w_br_live = ex_br & ex_valid;
    assign w_capture = ~stall_dcache & ~flush_all;

    // A lane is killed by any valid mispredicted branch in an older lane.
    generate
        for (genvar j = 0; j < LANES; j++) begin : g_kill
            if (j == 0) begin : g_oldest
                assign w_kill[j] = 1'b0;
            end else begin : g_younger
                assign w_kill[j] = |w_br_live[j-1:0];
            end
        end
    endgenerate

    always_comb begin
        w_kill_pop = '0;
        for (int j = 0; j < LANES; j++) begin
            w_kill_pop = w_kill_pop + {2'b00, ex_valid[j] & w_kill[j]};
        end
    end

    assign w_kill_sum = {1'b0, kill_cnt_q} + {30'd0, w_kill_pop};

    // MEM stage next state: flush beats stall, stall holds everything.
    always_comb begin
        mem_valid_d = mem_valid_q;
        mem_rf_we_d = mem_rf_we_q;
        mem_alu_d   = mem_alu_q;
        mem_waddr_d = mem_waddr_q;
        mem_mtype_d = mem_mtype_q;
        mem_wbsel_d = mem_wbsel_q;
        if (flush_all) begin
            mem_valid_d = '0;
            mem_rf_we_d = '0;
        end else if (!stall_dcache) begin
            for (int j = 0; j < LANES; j++) begin
                mem_valid_d[j] = ex_valid[j] & ~w_kill[j];
                mem_rf_we_d[j] = ex_rf_we[j] & ex_valid[j] & ~w_kill[j];
                mem_waddr_d[j*AW +: AW] = ex_rf_waddr[j*AW +: AW];
                if (w_kill[j]) begin
                    mem_alu_d[j*DW +: DW]    = '0;
                    mem_mtype_d[j*MTW +: MTW] = '0;
                    mem_wbsel_d[j*SW +: SW]   = '0;
                end else begin
                    mem_alu_d[j*DW +: DW]    = ex_alu_result[j*DW +: DW];
                    mem_mtype_d[j*MTW +: MTW] = ex_mem_type[j*MTW +: MTW];
                    mem_wbsel_d[j*SW +: SW]   = ex_wb_sel[j*SW +: SW];
                end
            end
        end
    end

    // WB ignores flush; a stall inserts a bubble so a held MEM op retires once.
    always_comb begin
        wb_valid_d = wb_valid_q;
        wb_rf_we_d = wb_rf_we_q;
        wb_alu_d   = wb_alu_q;
        wb_wdata_d = wb_wdata_q;
        wb_waddr_d = wb_waddr_q;
        if (stall_dcache) begin
            wb_valid_d = '0;
            wb_rf_we_d = '0;
        end else begin
            wb_valid_d = mem_valid_q;
            wb_rf_we_d = mem_rf_we_q;
            wb_alu_d   = mem_alu_q;
            wb_wdata_d = mem_rf_wdata;
            wb_waddr_d = mem_waddr_q;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        kill_cnt_d  = kill_cnt_q;
        if (stall_dcache && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (w_capture) begin
            kill_cnt_d = w_kill_sum[32] ? 32'hFFFF_FFFF : w_kill_sum[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid_q <= '0;
            mem_rf_we_q <= '0;
            mem_alu_q   <= '0;
            mem_waddr_q <= '0;
            mem_mtype_q <= '0;
            mem_wbsel_q <= '0;
            wb_valid_q  <= '0;
            wb_rf_we_q  <= '0;
            wb_alu_q    <= '0;
            wb_wdata_q  <= '0;
            wb_waddr_q  <= '0;
            stall_cnt_q <= '0;
            kill_cnt_q  <= '0;
        end else begin
            mem_valid_q <= mem_valid_d;
            mem_rf_we_q <= mem_rf_we_d;
            mem_alu_q   <= mem_alu_d;
            mem_waddr_q <= mem_waddr_d;
            mem_mtype_q <= mem_mtype_d;
            mem_wbsel_q <= mem_wbsel_d;
            wb_valid_q  <= wb_valid_d;
            wb_rf_we_q  <= wb_rf_we_d;
            wb_alu_q    <= wb_alu_d;
            wb_wdata_q  <= wb_wdata_d;
            wb_waddr_q  <= wb_waddr_d;
            stall_cnt_q <= stall_cnt_d;
            kill_cnt_q  <= kill_cnt_d;
        end
    end

    assign mem_valid      = mem_valid_q;
    assign mem_rf_we      = mem_rf_we_q;
    assign mem_alu_result = mem_alu_q;
    assign mem_rf_waddr   = mem_waddr_q;
    assign mem_mem_type   = mem_mtype_q;
    assign mem_wb_sel     = mem_wbsel_q;
    assign wb_valid       = wb_valid_q;
    assign wb_rf_we       = wb_rf_we_q;
    assign wb_alu_result  = wb_alu_q;
    assign wb_rf_wdata    = wb_wdata_q;
    assign wb_rf_waddr    = wb_waddr_q;
    assign stall_cnt      = stall_cnt_q;
    assign kill_cnt       = kill_cnt_q;

endmodule
`default_nettype wire

// File: doc/pipe_reg_multi.md
PIPE_REG_MULTI -- requirements
Module: pipe_reg_multi

Interface
REQ-001 Parameter LANES, default 2, number of issue lanes (1..4); lane 0 is oldest in program order.
REQ-002 Parameter DW, default 32, data width; parameter AW, default 5, register address width.
REQ-003 Parameters MTW, default 3, mem-type width, and SW, default 6, wb-mux-select width.
REQ-004 Clocking is one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock, all state updates on its rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 stall_dcache  in  1  dcache busy; holds MEM stage.
REQ-008 flush_all  in  1  exception/redirect flush of EX capture and MEM stage.
REQ-009 ex_valid, ex_br, ex_rf_we  in  LANES each  per-lane valid, branch-mispredict-in-EX, RF write enable.
REQ-010 ex_alu_result  in  LANES*DW  and  ex_rf_waddr  in  LANES*AW  and  ex_mem_type  in  LANES*MTW  and  ex_wb_sel  in  LANES*SW  per-lane EX payload, lane i in slice i.
REQ-011 mem_valid, mem_rf_we  out  LANES;  mem_alu_result, mem_rf_waddr, mem_mem_type, mem_wb_sel  out  matching widths  registered MEM payload.
REQ-012 mem_rf_wdata  in  LANES*DW  final write data computed in MEM.
REQ-013 wb_valid, wb_rf_we  out  LANES;  wb_alu_result, wb_rf_wdata  out  LANES*DW;  wb_rf_waddr  out  LANES*AW  registered WB payload.
REQ-014 stall_cnt, kill_cnt  out  32 each  saturating performance counters.

Function
REQ-015 Kill mask: lane j is killed when ex_br[i]=1 and ex_valid[i]=1 for some i<j; lane carrying the mispredicted branch itself is not killed.
REQ-016 EX->MEM capture when stall_dcache=0 and flush_all=0: mem_valid[j]<=ex_valid[j]&~kill[j]; mem_rf_we[j]<=ex_rf_we[j]&ex_valid[j]&~kill[j]; all other mem payload copied unconditionally.
REQ-017 Killed lanes: mem_alu_result and mem_wb_sel forced to 0, mem_mem_type forced to 0 (no access).
REQ-018 stall_dcache=1 and flush_all=0: every mem_* register holds its value.
REQ-019 flush_all=1: mem_valid and mem_rf_we cleared to 0 regardless of stall_dcache; payload don't-care but held.
REQ-020 MEM->WB when stall_dcache=0: wb_valid<=mem_valid, wb_rf_we<=mem_rf_we, wb payload copied from mem_* and mem_rf_wdata.
REQ-021 stall_dcache=1: wb_valid and wb_rf_we cleared (bubble) so a held MEM instruction is written back exactly once; wb payload holds.
REQ-022 flush_all does not affect WB stage in the same cycle (instructions already in MEM at flush time are killed, WB-stage ones retire).
REQ-023 Priority per stage: rst > flush_all > stall_dcache > normal advance.
REQ-024 Latency: EX inputs visible on mem_* 1 cycle after capture edge, on wb_* 1 cycle after MEM advances.
REQ-025 stall_cnt increments by 1 each cycle stall_dcache=1; saturates at 32'hFFFF_FFFF.
REQ-026 kill_cnt adds popcount(ex_valid & kill) on each capture edge (REQ-016 conditions); saturates at 32'hFFFF_FFFF, no wrap.
REQ-027 LANES=1: kill mask constant 0; behaviour otherwise identical.

Reset
REQ-028 rst=1 at a rising edge: all mem_* and wb_* outputs, stall_cnt and kill_cnt become 0 that edge.
REQ-029 rst asserted mid-stall or mid-flush: reset wins; first post-reset cycle behaves as normal advance.

Verification
REQ-030 LANES=2, ex_valid=11, ex_rf_we=11, ex_br=00, results A/B -> next edge mem_valid=11, mem_alu_result={B,A}; following edge wb_valid=11.
REQ-031 ex_valid=11, ex_br=01 -> mem_valid=01, mem_rf_we[1]=0, mem_alu_result[1]=0, kill_cnt +1.
REQ-032 stall_dcache high 3 cycles with valid MEM -> mem_* held, wb_valid=00 during stall, single wb_valid=11 pulse after release, stall_cnt=3.
REQ-033 flush_all with stall_dcache=1 -> mem_valid=00 next edge; WB receives bubble; no write back of flushed lane.
REQ-034 Force kill_cnt to 32'hFFFF_FFFE, kill 2 lanes -> kill_cnt=32'hFFFF_FFFF, stays there on further kills.
REQ-035 rst pulse during stall with valid MEM/WB -> all outputs and counters 0 next edge; normal capture resumes the cycle after.
